// File: rtl/tdm_demux1_2_if.sv
// Handshake bundle for the 1:2 TDM demux.
// Interleaved beats in, registered channel pairs out.
interface tdm_demux1_2_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic [DATA_W-1:0] in_data;
  logic              in_sof;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out1;
  logic [DATA_W-1:0] out2;
  logic              out_valid;
  logic              out_ready;
  logic              sync_err;
  logic [CNT_W-1:0]  pair_cnt;

  modport master (
    output in_data,
    output in_sof,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out1,
    input  out2,
    input  out_valid,
    input  sync_err,
    input  pair_cnt
  );

  modport slave (
    input  in_data,
    input  in_sof,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out1,
    output out2,
    output out_valid,
    output sync_err,
    output pair_cnt
  );
endinterface

// File: rtl/tdm_demux1_2.sv
// 1:2 TDM demux: pairs sof-tagged ch1 word with the next ch2 word.
// Optional hold timeout: define TDM_DEMUX_TIMEOUT_EN.
module tdm_demux1_2 #(
  parameter int DATA_W      = 8,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 16
) (
  input logic           sys_clk,
  input logic           sys_rst_n,
  tdm_demux1_2_if.slave bus
);

  typedef enum logic {
    S_WAIT,
    S_GOT1
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] out1_q;
  logic [DATA_W-1:0] out2_q;
  logic              out_valid_q;
  logic              sync_err_q;
  logic [CNT_W-1:0]  pair_cnt_q;

  logic in_ready;
  logic accept;
  logic consume;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  assign consume  = out_valid_q && bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out1      = out1_q;
  assign bus.out2      = out2_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sync_err  = sync_err_q;
  assign bus.pair_cnt  = pair_cnt_q;

`ifdef TDM_DEMUX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] tmo;
  logic          tmo_hit;

  // Fires on the idle edge that would bring the count to TIMEOUT_CYC.
  assign tmo_hit = (state == S_GOT1) && !accept && (tmo == TMO_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tmo <= '0;
    end else if (accept || state != S_GOT1 || tmo_hit) begin
      tmo <= '0;
    end else begin
      tmo <= tmo + 1'b1;
    end
  end
`else
  logic tmo_hit;
  logic unused_tmo;

  assign tmo_hit    = 1'b0;
  assign unused_tmo = (TIMEOUT_CYC != 0);
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= S_WAIT;
      hold        <= '0;
      out1_q      <= '0;
      out2_q      <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      pair_cnt_q  <= '0;
    end else begin
      sync_err_q <= 1'b0;

      if (consume) begin
        pair_cnt_q  <= pair_cnt_q + 1'b1;
        out_valid_q <= 1'b0;
      end

      unique case (state)
        S_WAIT: begin
          if (accept) begin
            if (bus.in_sof) begin
              hold  <= bus.in_data;
              state <= S_GOT1;
            end else begin
              sync_err_q <= 1'b1;
            end
          end
        end
        S_GOT1: begin
          if (accept) begin
            if (bus.in_sof) begin
              hold       <= bus.in_data;
              sync_err_q <= 1'b1;
            end else begin
              // Load wins over a same-cycle consume.
              out1_q      <= hold;
              out2_q      <= bus.in_data;
              out_valid_q <= 1'b1;
              state       <= S_WAIT;
            end
          end else if (tmo_hit) begin
            sync_err_q <= 1'b1;
            state      <= S_WAIT;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_demux1_2.sv
// Scoreboard bench for tdm_demux1_2.
// Driver pushes expected pairs; negedge monitor pops on consume.
module tb_tdm_demux1_2;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;
  localparam int TMO    = 16;

  logic sys_clk;
  logic sys_rst_n;

  tdm_demux1_2_if #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) bus ();

  tdm_demux1_2 #(
    .DATA_W     (DATA_W),
    .CNT_W      (CNT_W),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   sync_cnt = 0;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, req);
    end
  endtask

  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (bus.sync_err) sync_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_pair", {bus.out1, bus.out2}, 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("pair_out1", bus.out1, e.a);
          chk("pair_out2", bus.out2, e.b);
          if (e.cyc >= 0) chk("pair_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Entered and left just after a rising edge.
  task automatic send(input logic [7:0] d, input logic s);
    int n;
    bus.in_data  = d;
    bus.in_sof   = s;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    if (n == 50) chk("send_timeout", 32'(n), 32'(0));
    @(posedge sys_clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic push(input logic [7:0] a,
                      input logic [7:0] b,
                      input bit timed);
    exp_t e;
    e.a   = a;
    e.b   = b;
    e.cyc = timed ? cyc : -1;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  logic [7:0] stream [8];
  int         s0;

  initial begin
    stream = '{8'h10, 8'h20, 8'h31, 8'h42,
               8'h53, 8'h64, 8'h75, 8'h86};
    sys_rst_n     = 1'b0;
    bus.in_data   = '0;
    bus.in_sof    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out1", bus.out1, 8'h00);
    chk("rst_out2", bus.out2, 8'h00);
    chk("rst_pair_cnt", bus.pair_cnt, 16'd0);
    chk("rst_sync_err", bus.sync_err, 1'b0);
    sys_rst_n = 1'b1;
    idle(1);

    // Single pair.
    s0 = sync_cnt;
    send(8'hA1, 1'b1);
    send(8'hB2, 1'b0);
    push(8'hA1, 8'hB2, 1'b1);
    idle(3);
    chk("t1_pair_cnt", bus.pair_cnt, 16'd1);
    chk("t1_sync", sync_cnt - s0, 0);

    // Back-to-back stream, four pairs.
    for (int i = 0; i < 8; i += 2) begin
      send(stream[i], 1'b1);
      send(stream[i+1], 1'b0);
      push(stream[i], stream[i+1], 1'b1);
    end
    idle(3);
    chk("t2_pair_cnt", bus.pair_cnt, 16'd5);
    chk("t2_sb_empty", sb.size(), 0);

    // Backpressure with a pending sof beat.
    bus.out_ready = 1'b0;
    send(8'h5C, 1'b1);
    send(8'h6D, 1'b0);
    push(8'h5C, 8'h6D, 1'b0);
    bus.in_data  = 8'hC3;
    bus.in_sof   = 1'b1;
    bus.in_valid = 1'b1;
    repeat (5) begin
      @(negedge sys_clk);
      chk("bp_valid", bus.out_valid, 1'b1);
      chk("bp_out1", bus.out1, 8'h5C);
      chk("bp_out2", bus.out2, 8'h6D);
      chk("bp_in_ready", bus.in_ready, 1'b0);
      @(posedge sys_clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(negedge sys_clk);
    chk("bp_release_ready", bus.in_ready, 1'b1);
    @(posedge sys_clk);
    #1;
    bus.in_valid = 1'b0;
    chk("bp_consumed", bus.out_valid, 1'b0);
    send(8'hD4, 1'b0);
    push(8'hC3, 8'hD4, 1'b1);
    idle(3);
    chk("t3_pair_cnt", bus.pair_cnt, 16'd7);

    // Framing errors and resync.
    s0 = sync_cnt;
    send(8'h11, 1'b0);
    send(8'h22, 1'b1);
    send(8'h33, 1'b1);
    send(8'h44, 1'b0);
    push(8'h33, 8'h44, 1'b1);
    idle(3);
    chk("t4_sync", sync_cnt - s0, 2);
    chk("t4_pair_cnt", bus.pair_cnt, 16'd8);

    // Asynchronous reset mid-pair.
    send(8'h5A, 1'b1);
    #1;
    sys_rst_n = 1'b0;
    #1;
    chk("ar_out_valid", bus.out_valid, 1'b0);
    chk("ar_out1", bus.out1, 8'h00);
    chk("ar_out2", bus.out2, 8'h00);
    chk("ar_pair_cnt", bus.pair_cnt, 16'd0);
    chk("ar_sync_err", bus.sync_err, 1'b0);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    s0 = sync_cnt;
    send(8'h55, 1'b0);
    idle(3);
    chk("ar_sync", sync_cnt - s0, 1);
    chk("ar_pair_cnt2", bus.pair_cnt, 16'd0);

    // Hold timeout (or indefinite hold).
    s0 = sync_cnt;
    send(8'h66, 1'b1);
    idle(TMO);
    send(8'h77, 1'b0);
`ifdef TDM_DEMUX_TIMEOUT_EN
    idle(3);
    chk("to_sync", sync_cnt - s0, 2);
    chk("to_pair_cnt", bus.pair_cnt, 16'd0);
`else
    push(8'h66, 8'h77, 1'b1);
    idle(3);
    chk("to_sync", sync_cnt - s0, 0);
    chk("to_pair_cnt", bus.pair_cnt, 16'd1);
`endif

    chk("final_sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/tdm_demux1_2.md
Name: tdm_demux1_2

Overview:
- Receive-side counterpart of the team's 2:1 mux path: one time-interleaved input stream carries channel 1 and channel 2 words alternately; this block splits it back into two parallel outputs.
- Input beats are tagged with a start-of-frame flag marking the channel-1 word.
- The held channel-1 word is paired with the following channel-2 word and presented on out1/out2 as one registered, handshaked pair.
- Sits between the link receiver and the per-channel consumers.

Parameters:
- DATA_W, 8, width of each data word.
- CNT_W, 16, width of the emitted-pair counter.
- TIMEOUT_CYC, 16, idle cycles allowed while holding a channel-1 word; used only with the optional feature.

Ports:
- sys_clk  input  1  system clock, rising edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- in_data  input  DATA_W  interleaved input word.
- in_sof  input  1  1 = this beat is the channel-1 word.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- out1  output  DATA_W  channel-1 word of the current pair.
- out2  output  DATA_W  channel-2 word of the current pair.
- out_valid  output  1  out1/out2 hold a valid pair.
- out_ready  input  1  consumer accepts the pair.
- sync_err  output  1  one-cycle pulse when a word is dropped for framing reasons.
- pair_cnt  output  CNT_W  number of pairs accepted by the consumer, wraps.

Behaviour:
- Reset (async assert, sync release): state=S_WAIT; hold reg=0; out1=out2=0; out_valid=0; sync_err=0; pair_cnt=0. Reset mid-pair discards the held word silently, with no sync_err.
- Definitions: accept = in_valid && in_ready. in_ready = !out_valid || out_ready, identical in every state and combinational.
- sync_err defaults to 0 every cycle; it is only pulsed by the events below.
- State S_WAIT (no word held):
  - accept with in_sof=1 -> hold<=in_data; go to S_GOT1.
  - accept with in_sof=0 -> word dropped; sync_err=1 next cycle; stay in S_WAIT.
- State S_GOT1 (channel-1 word held):
  - accept with in_sof=0 -> out1<=hold; out2<=in_data; out_valid<=1; go to S_WAIT. Pair appears the cycle after the channel-2 beat (latency 1).
  - accept with in_sof=1 -> resync: old held word dropped; hold<=in_data; sync_err=1; stay in S_GOT1.
- Output register:
  - out_valid && out_ready -> pair consumed; pair_cnt<=pair_cnt+1, wrapping at 2^CNT_W to 0.
  - Consume and a new pair load in the same cycle -> out_valid stays 1 with the new data; pair_cnt still increments.
  - Consume with no load -> out_valid<=0. out1/out2 keep their last values.
  - out1/out2 are stable while out_valid && !out_ready.
- Backpressure: while out_valid && !out_ready, in_ready=0. No beat is accepted in either state, so the hold reg is never overwritten while the consumer is stalled.
- Throughput: one pair every 2 accepted beats, with no bubbles when out_ready=1 continuously.

Optional Feature:
- Macro: TDM_DEMUX_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYC+1) clears on entry to S_GOT1 and on every accept.
  - It increments each cycle spent in S_GOT1 without an accept.
  - When it reaches TIMEOUT_CYC: the held word is dropped, sync_err pulses, state returns to S_WAIT, and the counter clears.
  - Cycles with in_ready=0 still count.
- Not defined: no counter. S_GOT1 waits indefinitely; TIMEOUT_CYC is unused.

Test Plan:
- Reset, then beats (0xA1,sof=1),(0xB2,sof=0) with out_ready=1 -> next cycle out1=0xA1, out2=0xB2, out_valid=1 for one cycle; pair_cnt=1; sync_err never 1.
- Continuous stream of 8 beats (4 pairs) with in_valid=1 and out_ready=1 -> 4 pairs, one on every second cycle, each appearing 1 cycle after its channel-2 beat; pair_cnt=4.
- Pair loaded, out_ready=0 for 5 cycles -> out_valid=1, out1/out2 frozen, in_ready=0. Raising out_ready -> consumed the same cycle; in_ready=1.
- Beats (0x11,sof=0) in S_WAIT, then (0x22,sof=1),(0x33,sof=1),(0x44,sof=0) -> two sync_err pulses; only pair out1=0x33, out2=0x44 is emitted.
- sys_rst_n asserted asynchronously after the sof beat, then released, then beat (0x55,sof=0) -> outputs immediately 0; no pair; one sync_err pulse for 0x55.
- With TDM_DEMUX_TIMEOUT_EN and TIMEOUT_CYC=16: sof beat 0x66 then 16 idle cycles -> sync_err pulses; then (0x77,sof=0) -> dropped with a second sync_err, no pair. Without the macro, the same stimulus gives pair 0x66/0x77.
